// File: rtl/tv80_alu16_seq.sv
// rtl/tv80_alu16_seq.sv - two-pass 16-bit ADD/ADC/SBC/SUB sequencer driving the 8-bit TV80 ALU
module tv80_alu16_seq #(
    parameter int Flag_C = 0,
    parameter int Flag_Z = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  f_in,
    input  logic        abort,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_result,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [1:0] ADD16 = 2'b00;

    state_t      state;
    logic [1:0]  op_r;
    logic [15:0] opa_r;
    logic [15:0] opb_r;
    logic [7:0]  f_in_r;
    logic [7:0]  q_lo;
    logic [7:0]  f_lo;
    logic [7:0]  hi_f_in;

    // The high pass consumes the low pass flags: C as carry-in, Z for the 16-bit zero chain.
    always_comb begin
        hi_f_in         = f_lo;
        hi_f_in[Flag_C] = f_lo[Flag_C];
        hi_f_in[Flag_Z] = f_lo[Flag_Z];
    end

    always_comb begin
        alu_op      = 4'b0000;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;
        case (state)
            LO: begin
                alu_op      = {2'b00, op_r[1], op_r[1] ^ op_r[0]};
                alu_arith16 = (op_r == ADD16);
                alu_busa    = opa_r[7:0];
                alu_busb    = opb_r[7:0];
                alu_f_in    = f_in_r;
            end
            HI: begin
                alu_op      = op_r[1] ? 4'b0011 : 4'b0001;
                alu_arith16 = (op_r == ADD16);
                alu_z16     = (op_r != ADD16);
                alu_busa    = opa_r[15:8];
                alu_busb    = opb_r[15:8];
                alu_f_in    = hi_f_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= 16'h0000;
            f_result <= 8'h00;
            op_r     <= 2'b00;
            opa_r    <= 16'h0000;
            opb_r    <= 16'h0000;
            f_in_r   <= 8'h00;
            q_lo     <= 8'h00;
            f_lo     <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        op_r   <= op;
                        opa_r  <= opa;
                        opb_r  <= opb;
                        f_in_r <= f_in;
                        ready  <= 1'b0;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (abort) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        q_lo  <= alu_q;
                        f_lo  <= alu_f_out;
                        state <= HI;
                    end
                end
                HI: begin
                    if (abort) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        result   <= {alu_q, q_lo};
                        f_result <= alu_f_out;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb/tb_tv80_alu16_seq.sv - directed scoreboard bench for tv80_alu16_seq with a behavioural 8-bit ALU
module tb_tv80_alu16_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = 16'h0000;
    logic [15:0] opb = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic        ready, done;
    logic [15:0] result;
    logic [7:0]  f_result;
    logic [3:0]  alu_op;
    logic        alu_arith16, alu_z16;
    logic [7:0]  alu_busa, alu_busb, alu_f_in;
    logic [7:0]  alu_q, alu_f_out;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    tv80_alu16_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .f_in(f_in), .abort(abort), .ready(ready), .done(done), .result(result),
        .f_result(f_result), .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
        .alu_q(alu_q), .alu_f_out(alu_f_out)
    );

    // Behavioural TV80 ALU for ops 0-3 (ADD/ADC/SUB/SBC); flags S Z Y H X P N C = bits 7..0.
    function automatic logic [15:0] alu_model(input logic [3:0] aop, input logic a16, input logic z16,
                                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi);
        logic       sub, cin, ov;
        logic [7:0] bb, q, f;
        logic [8:0] s9;
        logic [4:0] h5;
        sub = aop[1];
        cin = sub ^ (aop[0] & fi[0]);
        bb  = sub ? ~b : b;
        s9  = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
        h5  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'h0, cin};
        q   = s9[7:0];
        ov  = (a[7] == bb[7]) && (q[7] != a[7]);
        f[0] = sub ? ~s9[8] : s9[8];
        f[1] = sub;
        f[2] = ov;
        f[3] = q[3];
        f[4] = sub ? ~h5[4] : h5[4];
        f[5] = q[5];
        f[6] = (q == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
        f[7] = q[7];
        if (a16) begin
            f[7] = fi[7];
            f[6] = fi[6];
            f[2] = fi[2];
        end
        return {q, f};
    endfunction

    always_comb {alu_q, alu_f_out} = alu_model(alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        compared++;
        assert (sb.size() > 0) else begin
            mismatched++;
            $error("FAIL sb_underflow: observed done with %0d expected entries, expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("f_result", {8'h00, f_result}, {8'h00, e.flg});
        end
    endtask

    // Entered and left just after a falling edge; poke pulses start during LO and HI.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f, input logic [15:0] er, input logic [7:0] ef,
                          input logic poke);
        logic [3:0] lo_op, hi_op;
        lo_op = (o == 2'b00) ? 4'h0 : (o == 2'b01) ? 4'h1 : (o == 2'b10) ? 4'h3 : 4'h2;
        hi_op = o[1] ? 4'h3 : 4'h1;
        check("ready_before_start", ready, 1'b1);
        start = 1'b1; op = o; opa = a; opb = b; f_in = f;
        sb.push_back('{er, ef});
        @(negedge clk);
        start = poke;
        if (poke) begin opa = 16'hFFFF; opb = 16'hFFFF; op = 2'b10; end
        check("lo_ready", ready, 1'b0);
        check("lo_alu_op", alu_op, lo_op);
        check("lo_busa", alu_busa, a[7:0]);
        check("lo_arith16", alu_arith16, o == 2'b00);
        @(negedge clk);
        check("hi_done", done, 1'b0);
        check("hi_alu_op", alu_op, hi_op);
        check("hi_busb", alu_busb, b[15:8]);
        check("hi_z16", alu_z16, o != 2'b00);
        @(negedge clk);
        start = 1'b0;
        check("done_latency", done, 1'b1);
        if (done) pop_and_check();
        @(negedge clk);
        check("ready_after_done", ready, 1'b1);
        check("done_one_cycle", done, 1'b0);
        check("idle_alu_op", alu_op, 4'h0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_f_result", {8'h00, f_result}, 16'h0000);
        check("rst_alu_busa", alu_busa, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 16'h1234, 16'h0FCD, 8'hC4, 16'h2201, 8'hF4, 1'b0);
        run_op(2'b10, 16'h0000, 16'h0001, 8'h01, 16'hFFFE, 8'hBB, 1'b0);
        run_op(2'b01, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h45, 1'b0);
        run_op(2'b11, 16'h0100, 16'h0001, 8'h00, 16'h00FF, 8'h02, 1'b0);

        run_op(2'b00, 16'h1234, 16'h0FCD, 8'hC4, 16'h2201, 8'hF4, 1'b1);
        count_dones(4, n);
        check("no_queued_start", n[15:0], 16'd0);

        start = 1'b1; op = 2'b11; opa = 16'h0005; opb = 16'h0003; f_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", done, 1'b0);
        check("abort_ready", ready, 1'b1);
        check("abort_result", result, 16'h2201);
        check("abort_f_result", {8'h00, f_result}, 16'h00F4);
        count_dones(3, n);
        check("abort_no_done", n[15:0], 16'd0);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", ready, 1'b1);

        start = 1'b1; op = 2'b01; opa = 16'h4321; opb = 16'h1111; f_in = 8'h01;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 16'h00FF, 16'h0001, 8'hFF, 16'h0100, 8'hC4, 1'b0);

        check("sb_drained", sb.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
